sm_regdump: RTL and testbench
=============================

# sm_regdump

Debug register-dump sequencer: the initiator on the CPU register-inspection port (drives `regAddr`, consumes `regData`). On a start request it walks a range of CPU registers, formats each value as ASCII hex, and transmits it on a UART TX line (8N1). It sits beside `sm_cpu` in the top level, on the same clock as the CPU core, giving a board-level serial dump of register state without a display.

## Interface
- `BAUD_DIV`, 434: clock cycles per UART bit (≥2).
- `READ_LAT`, 2: cycles between driving `regAddr` and sampling `regData` (≥1).
- `REG_FIRST`, 0: first register index dumped.
- `REG_LAST`, 31: last register index dumped (≥ `REG_FIRST`).

- `clk`  in  1: system clock (same clock as `sm_cpu`).
- `rst_n`  in  1: reset; one clock; reset is asynchronous and active-low.
- `start`  in  1: dump request, sampled each rising edge; already synchronous to `clk`.
- `busy`  out  1: high while a dump is in progress.
- `regAddr`  out  5: register index to the CPU inspection port.
- `regData`  in  32: register value from the CPU inspection port.
- `tx`  out  1: UART serial output, idle high.

## Operation
- Reset values: `tx`=1, `busy`=0, `regAddr`=`REG_FIRST`, FSM in IDLE, all counters 0.
- FSM states: IDLE → ADDR → SEND → NEXT → (ADDR | IDLE).
  - IDLE: `start`=1 → ADDR; `regAddr` ← `REG_FIRST`; `busy` ← 1.
  - ADDR: hold `regAddr`; after `READ_LAT` cycles latch `regData` into a 32-bit capture register → SEND; byte index ← 0.
  - SEND: transmit line bytes in order; advance after each stop bit completes; after the last byte → NEXT.
  - NEXT: `regAddr` = `REG_LAST` → IDLE, `busy` ← 0; otherwise `regAddr` ← `regAddr`+1 → ADDR.
- Line format (no index): 8 hex digits of the captured value, MS nibble first, then 0x0D, 0x0A; 10 bytes per register.
- Hex encoding: nibble 0–9 → 0x30+n; A–F → 0x37+n (uppercase).
- UART frame: start bit 0, 8 data bits LSB first, stop bit 1; each bit held exactly `BAUD_DIV` cycles; consecutive bytes back-to-back (no idle gap).
- `start` while `busy`=1 is ignored; no queuing.
- `regData` is sampled only once per register, at the end of ADDR; later changes do not affect the line in flight.
- `rst_n` low mid-frame: all state returns to reset values immediately; `tx` goes high asynchronously, truncating the frame.

## Timing
- `start` high at edge N → `busy`=1 and `regAddr`=`REG_FIRST` after edge N; capture at edge N+`READ_LAT`+1.
- First start bit (`tx`=0) begins at the cycle after capture.
- Per register: `READ_LAT` + 1 (ADDR/NEXT overhead) + bytes×10×`BAUD_DIV` cycles.
- `busy` falls at the edge after the final stop bit of register `REG_LAST` completes; `start` may be accepted at that same IDLE cycle onward.
- `regAddr` never wraps: the dump terminates at `REG_LAST`, including `REG_LAST`=31.

## Configuration
- `SM_REGDUMP_INDEX_EN` defined: each line is prefixed by the register index as 2 uppercase hex digits and ':' (0x3A), e.g. "1F:DEADBEEF\r\n"; 13 bytes per register.
- Not defined: no prefix, 10 bytes per register; the prefix logic is absent from the netlist.

## Structure
- Package `sm_regdump_pkg`: FSM state encoding, ASCII constants (CR, LF, colon, hex offsets 0x30/0x37), and the byte-count constants for both configurations.
- One sub-module, `sm_uart_tx`: baud counter + 10-bit shift register; ports `clk`, `rst_n`, `data[7:0]`, `valid`, `ready`, `tx`; accepts a byte when `valid`&&`ready`, and asserts `ready` at the cycle the stop bit ends, allowing back-to-back frames.

## Test plan
- Reset: hold `rst_n`=0 → `tx`=1, `busy`=0, `regAddr`=0; release, 100 cycles idle → `tx` stays 1.
- `BAUD_DIV`=4, `REG_FIRST`=`REG_LAST`=5, `regData`=0xDEADBEEF, pulse `start` → bench UART decoder receives "DEADBEEF\r\n" (index prefix "05:" with macro), each bit 4 cycles, `busy` low after exactly 2+1+400 (or 520) cycles.
- Full range 0..31, `regData`=`regAddr`×0x01010101 → 32 lines, line k = hex of k×0x01010101; `regAddr` stops at 31 with no wrap.
- `start` pulses during `busy` → ignored: the output is byte-identical to a single dump, and `busy` falls once.
- `regData` changed 1 cycle after capture → transmitted value is the pre-change value.
- `rst_n` asserted mid-byte of register 3 → `tx`=1 immediately, `busy`=0; a fresh `start` dumps again from `REG_FIRST`.

Source files
------------

// File: rtl/sm_regdump_pkg.sv
// sm_regdump_pkg: shared types and constants for the register-dump sequencer.
// Optional feature macro: SM_REGDUMP_INDEX_EN (adds "NN:" index prefix to each line).
package sm_regdump_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_SEND = 2'd2,
        ST_NEXT = 2'd3
    } state_t;

    localparam logic [7:0] ASCII_CR      = 8'h0D;
    localparam logic [7:0] ASCII_LF      = 8'h0A;
    localparam logic [7:0] ASCII_COLON   = 8'h3A;
    localparam logic [7:0] HEX_OFF_DIGIT = 8'h30;
    localparam logic [7:0] HEX_OFF_ALPHA = 8'h37;

    localparam int LINE_BYTES_NOIDX = 10;
    localparam int LINE_BYTES_IDX   = 13;
    localparam int PREFIX_BYTES     = 3;

`ifdef SM_REGDUMP_INDEX_EN
    localparam int LINE_BYTES = LINE_BYTES_IDX;
`else
    localparam int LINE_BYTES = LINE_BYTES_NOIDX;
`endif

    function automatic logic [7:0] hex_ascii(input logic [3:0] n);
        return (n < 4'd10) ? (HEX_OFF_DIGIT + {4'b0000, n}) : (HEX_OFF_ALPHA + {4'b0000, n});
    endfunction

    // Payload byte idx of a line: 8 hex digits MS nibble first, then CR, LF.
    function automatic logic [7:0] line_byte(input logic [3:0] idx, input logic [31:0] value);
        logic [4:0] lsb;
        lsb = 5'd28 - {idx[2:0], 2'b00};
        if (idx < 4'd8)       return hex_ascii(value[lsb +: 4]);
        else if (idx == 4'd8) return ASCII_CR;
        else                  return ASCII_LF;
    endfunction

`ifdef SM_REGDUMP_INDEX_EN
    // Prefix byte idx: two hex digits of the 5-bit index, then ':'.
    function automatic logic [7:0] prefix_byte(input logic [3:0] idx, input logic [4:0] addr);
        if (idx == 4'd0)      return hex_ascii({3'b000, addr[4]});
        else if (idx == 4'd1) return hex_ascii(addr[3:0]);
        else                  return ASCII_COLON;
    endfunction
`endif

endpackage

// File: rtl/sm_uart_tx.sv
// sm_uart_tx: 8N1 transmitter, one byte per valid&&ready, back-to-back capable.
module sm_uart_tx #(
    parameter int BAUD_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] data,
    input  logic       valid,
    output logic       ready,
    output logic       tx
);

    localparam int BW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;

    logic          active_q;
    logic [9:0]    shreg_q;
    logic [3:0]    bit_cnt_q;
    logic [BW-1:0] baud_cnt_q;
    logic          frame_end;

    assign frame_end = active_q && (bit_cnt_q == 4'd0) && (baud_cnt_q == '0);
    assign ready     = !active_q || frame_end;
    // Combinational from active_q so reset forces the line high without a clock.
    assign tx        = active_q ? shreg_q[0] : 1'b1;

    // Frame shifter: load on accept, hold each bit BAUD_DIV cycles, then shift.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            active_q   <= 1'b0;
            shreg_q    <= '1;
            bit_cnt_q  <= '0;
            baud_cnt_q <= '0;
        end else if (valid && ready) begin
            active_q   <= 1'b1;
            shreg_q    <= {1'b1, data, 1'b0};
            bit_cnt_q  <= 4'd9;
            baud_cnt_q <= BW'(BAUD_DIV - 1);
        end else if (active_q) begin
            if (baud_cnt_q != '0) begin
                baud_cnt_q <= baud_cnt_q - 1'b1;
            end else if (bit_cnt_q == 4'd0) begin
                active_q <= 1'b0;
            end else begin
                shreg_q    <= {1'b1, shreg_q[9:1]};
                bit_cnt_q  <= bit_cnt_q - 4'd1;
                baud_cnt_q <= BW'(BAUD_DIV - 1);
            end
        end
    end

endmodule

// File: rtl/sm_regdump.sv
// sm_regdump: walks CPU registers REG_FIRST..REG_LAST and prints each as an
// ASCII hex line on a UART. Optional macro: SM_REGDUMP_INDEX_EN.
//
// state | meaning
// IDLE  | waiting for start, busy low
// ADDR  | regAddr held for READ_LAT+1 cycles; last cycle captures regData and
//       | hands the first line byte (taken straight from regData) to the UART
// SEND  | feeds remaining line bytes as the UART frees up
// NEXT  | last byte queued; when its stop bit ends go to next register or IDLE
module sm_regdump
    import sm_regdump_pkg::*;
#(
    parameter int BAUD_DIV  = 434,
    parameter int READ_LAT  = 2,
    parameter int REG_FIRST = 0,
    parameter int REG_LAST  = 31
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic [4:0]  regAddr,
    input  logic [31:0] regData,
    output logic        tx
);

    localparam int LAT_W = $clog2(READ_LAT + 1);

    state_t           state_q, state_nxt;
    logic [4:0]       reg_addr_q;
    logic [31:0]      cap_q;
    logic [3:0]       byte_idx_q;
    logic [LAT_W-1:0] lat_cnt_q;
    logic             tx_valid, tx_ready;
    logic [7:0]       tx_data;
    logic [3:0]       byte_sel;
    logic [31:0]      payload_val;

    assign regAddr = reg_addr_q;
    assign busy    = (state_q != ST_IDLE);

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= ST_IDLE;
        else        state_q <= state_nxt;
    end

    // Next state, UART handshake and byte selection.
    always_comb begin
        state_nxt   = state_q;
        tx_valid    = 1'b0;
        byte_sel    = (state_q == ST_ADDR) ? 4'd0 : byte_idx_q;
        payload_val = (state_q == ST_ADDR) ? regData : cap_q;
`ifdef SM_REGDUMP_INDEX_EN
        if (byte_sel < 4'(PREFIX_BYTES)) tx_data = prefix_byte(byte_sel, reg_addr_q);
        else tx_data = line_byte(byte_sel - 4'(PREFIX_BYTES), payload_val);
`else
        tx_data = line_byte(byte_sel, payload_val);
`endif
        case (state_q)
            ST_IDLE: if (start) state_nxt = ST_ADDR;
            ST_ADDR: begin
                if (lat_cnt_q == '0) begin
                    tx_valid = 1'b1;
                    if (tx_ready) state_nxt = ST_SEND;
                end
            end
            ST_SEND: begin
                tx_valid = 1'b1;
                if (tx_ready && (byte_idx_q == 4'(LINE_BYTES - 1))) state_nxt = ST_NEXT;
            end
            ST_NEXT: begin
                if (tx_ready) state_nxt = (reg_addr_q == 5'(REG_LAST)) ? ST_IDLE : ST_ADDR;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Address, read-latency down-counter, capture and byte index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_addr_q <= 5'(REG_FIRST);
            cap_q      <= '0;
            byte_idx_q <= '0;
            lat_cnt_q  <= '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        reg_addr_q <= 5'(REG_FIRST);
                        lat_cnt_q  <= LAT_W'(READ_LAT);
                    end
                end
                ST_ADDR: begin
                    if (lat_cnt_q != '0) begin
                        lat_cnt_q <= lat_cnt_q - 1'b1;
                    end else if (tx_ready) begin
                        cap_q      <= regData;
                        byte_idx_q <= 4'd1;
                    end
                end
                ST_SEND: if (tx_ready) byte_idx_q <= byte_idx_q + 4'd1;
                ST_NEXT: begin
                    if (tx_ready && (reg_addr_q != 5'(REG_LAST))) begin
                        reg_addr_q <= reg_addr_q + 5'd1;
                        lat_cnt_q  <= LAT_W'(READ_LAT);
                    end
                end
                default: ;
            endcase
        end
    end

    sm_uart_tx #(.BAUD_DIV(BAUD_DIV)) u_uart_tx (
        .clk   (clk),
        .rst_n (rst_n),
        .data  (tx_data),
        .valid (tx_valid),
        .ready (tx_ready),
        .tx    (tx)
    );

endmodule

// File: tb/tb_sm_regdump.sv
// tb_sm_regdump: random-table register dumps decoded by a bench UART receiver
// and compared with the expected ASCII text built from the register table.
module tb_sm_regdump;

    localparam int BAUD  = 4;
    localparam int RL    = 2;
    localparam int FIRST = 0;
    localparam int LAST  = 31;
    localparam int NREG  = LAST - FIRST + 1;
`ifdef SM_REGDUMP_INDEX_EN
    localparam int LINE_BYTES = 13;
`else
    localparam int LINE_BYTES = 10;
`endif
    localparam int DUMP_CYC = NREG * (RL + 1 + LINE_BYTES * 10 * BAUD);

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic [4:0]  reg_addr;
    logic [31:0] reg_data = '0;
    logic        tx;

    int n_total = 0;
    int n_bad   = 0;

    logic [31:0] reg_tab [NREG];
    logic [7:0]  rx_q [$];
    logic [7:0]  exp_q [$];
    string       hex_digits = "0123456789ABCDEF";

    int         rx_glitch = 0;
    logic       rx_active = 1'b0;
    int         rx_cnt = 0;
    logic [9:0] rx_bits = '1;

    int         age = 0;
    logic       prev_busy = 1'b0;
    logic [4:0] prev_addr = '0;

    sm_regdump #(
        .BAUD_DIV (BAUD),
        .READ_LAT (RL),
        .REG_FIRST(FIRST),
        .REG_LAST (LAST)
    ) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .busy   (busy),
        .regAddr(reg_addr),
        .regData(reg_data),
        .tx     (tx)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // UART receiver: every bit must be steady for BAUD cycles, stop bit must be 1.
    always @(negedge clk) begin
        if (!rst_n) begin
            rx_active = 1'b0;
        end else if (!rx_active) begin
            if (tx == 1'b0) begin
                rx_active  = 1'b1;
                rx_bits[0] = 1'b0;
                rx_cnt     = 1;
            end
        end else begin
            if (rx_cnt % BAUD == 0) rx_bits[rx_cnt / BAUD] = tx;
            else if (tx != rx_bits[rx_cnt / BAUD]) rx_glitch++;
            rx_cnt++;
            if (rx_cnt == 10 * BAUD) begin
                if (rx_bits[9] != 1'b1) rx_glitch++;
                rx_q.push_back(rx_bits[8:1]);
                rx_active = 1'b0;
            end
        end
    end

    // Register port model: value valid for READ_LAT+1 cycles after the address
    // is presented, inverted afterwards so late or repeated sampling shows up.
    always @(negedge clk) begin
        if (busy && (!prev_busy || reg_addr != prev_addr)) age = 0;
        else if (age < 1000) age++;
        reg_data  = (age <= RL) ? reg_tab[reg_addr - 5'(FIRST)] : ~reg_tab[reg_addr - 5'(FIRST)];
        prev_busy = busy;
        prev_addr = reg_addr;
    end

    task automatic build_exp();
        int nib;
        exp_q.delete();
        for (int k = FIRST; k <= LAST; k++) begin
`ifdef SM_REGDUMP_INDEX_EN
            exp_q.push_back(hex_digits[k / 16]);
            exp_q.push_back(hex_digits[k % 16]);
            exp_q.push_back(8'h3A);
`endif
            for (int n = 7; n >= 0; n--) begin
                nib = int'((reg_tab[k - FIRST] >> (4 * n)) & 32'hF);
                exp_q.push_back(hex_digits[nib]);
            end
            exp_q.push_back(8'h0D);
            exp_q.push_back(8'h0A);
        end
    endtask

    task automatic run_dump(input string name, input bit start_noise);
        int base, glitch0, cyc, first_low, got;
        logic [4:0] prev_a;
        build_exp();
        base    = rx_q.size();
        glitch0 = rx_glitch;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        chk({name, "_busy_rise"}, busy, 1);
        chk({name, "_addr_first"}, reg_addr, FIRST);
        cyc = 0; first_low = -1; prev_a = 5'(FIRST);
        while (busy && cyc < DUMP_CYC + 200) begin
            if (!tx && first_low < 0) first_low = cyc;
            if (reg_addr != prev_a) begin
                chk({name, "_addr_step"}, reg_addr, prev_a + 1);
                prev_a = reg_addr;
            end
            @(negedge clk);
            cyc++;
            if (start_noise) start = ($urandom_range(0, 299) == 0);
        end
        start = 1'b0;
        chk({name, "_busy_cycles"}, cyc, DUMP_CYC);
        chk({name, "_first_start_bit"}, first_low, RL + 1);
        chk({name, "_addr_end"}, reg_addr, LAST);
        repeat (20) @(negedge clk);
        chk({name, "_idle_after"}, {busy, tx, reg_addr}, {1'b0, 1'b1, 5'(LAST)});
        chk({name, "_nbytes"}, rx_q.size() - base, exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (base + i < rx_q.size()) ? int'(rx_q[base + i]) : 0;
            chk($sformatf("%s_byte%0d", name, i), got, exp_q[i]);
        end
        chk({name, "_frame_errors"}, rx_glitch - glitch0, 0);
    endtask

    initial begin
        int lows, w;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_state", {tx, busy, reg_addr}, {1'b1, 1'b0, 5'd0});
        rst_n = 1'b1;
        lows = 0;
        repeat (100) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) lows++;
        end
        chk("idle_quiet", lows, 0);

        for (int k = 0; k < NREG; k++) reg_tab[k] = (FIRST + k) * 32'h01010101;
        run_dump("pattern", 1'b0);

        for (int k = 0; k < NREG; k++) reg_tab[k] = $urandom;
        run_dump("random_start_noise", 1'b1);

        // Abort a dump mid-frame on register 3.
        for (int k = 0; k < NREG; k++) reg_tab[k] = $urandom;
        @(negedge clk); start = 1'b1;
        @(negedge clk); start = 1'b0;
        w = 0;
        while (reg_addr != 5'd3 && w < 3000) begin @(negedge clk); w++; end
        chk("reach_reg3", reg_addr, 3);
        repeat ($urandom_range(20, 300)) @(negedge clk);
        w = 0;
        while (tx != 1'b0 && w < 100) begin @(negedge clk); w++; end
        chk("mid_frame_tx_low", tx, 0);
        rst_n = 1'b0;
        #1;
        chk("rst_async_tx", tx, 1);
        chk("rst_async_busy", busy, 0);
        chk("rst_async_addr", reg_addr, FIRST);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        for (int k = 0; k < NREG; k++) reg_tab[k] = $urandom;
        run_dump("after_reset", 1'b0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
